// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - two-axis VGA timing generator with chained h/v counters
// Optional feature macro: VGA_TIMING_RUNTIME_CFG_EN
//   defined   : timing values are runtime-writable through CFG_*; they are committed at frame wrap
//   undefined : timing values are the constant parameters and the CFG_* ports do not exist
// Ports:
//   CLK          system clock, all flops on posedge
//   RESET_N      asynchronous active-low reset
//   CE           pixel-rate enable; every register holds while CE=0
//   HSYNC/VSYNC  sync outputs, active level per H_POL/V_POL
//   DE           active-area flag
//   X/Y          current horizontal/vertical position
//   LINE_START   high while h==0
//   FRAME_START  high while h==0 && v==0
//   CFG_WR/CFG_ADDR/CFG_DATA/CFG_PENDING  (macro only) staging write port and pending flag
module vga_timing_gen #(
    parameter int CNT_W     = 12,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int H_POL     = 0,
    parameter int V_POL     = 0
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             CE,
    output logic             HSYNC,
    output logic             VSYNC,
    output logic             DE,
    output logic [CNT_W-1:0] X,
    output logic [CNT_W-1:0] Y,
    output logic             LINE_START,
    output logic             FRAME_START
`ifdef VGA_TIMING_RUNTIME_CFG_EN
    ,
    input  logic             CFG_WR,
    input  logic [2:0]       CFG_ADDR,
    input  logic [CNT_W-1:0] CFG_DATA,
    output logic             CFG_PENDING
`endif
);

    // Slot order: 0..7 = HD, HF, HS, HB, VD, VF, VS, VB
    typedef logic [7:0][CNT_W-1:0] timing_t;

    localparam timing_t DEF_TIMING = {
        CNT_W'(V_BACK), CNT_W'(V_SYNC), CNT_W'(V_FRONT), CNT_W'(V_DISPLAY),
        CNT_W'(H_BACK), CNT_W'(H_SYNC), CNT_W'(H_FRONT), CNT_W'(H_DISPLAY)
    };

    localparam logic [CNT_W-1:0] H_RST = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [CNT_W-1:0] V_RST = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic             HS_ON = (H_POL != 0);
    localparam logic             VS_ON = (V_POL != 0);

    timing_t          act_t;     // timing governing the current frame
    timing_t          nxt_t;     // timing governing the position being entered
    logic [CNT_W-1:0] h, v;
    logic [CNT_W-1:0] h_tot, v_tot;
    logic             h_last, v_last, wrap;
    logic [CNT_W-1:0] h_nx, v_nx;
    logic [CNT_W-1:0] hs_beg, hs_end, vs_beg, vs_end;
    logic             hs_in, vs_in, de_in;

    assign h_tot  = act_t[0] + act_t[1] + act_t[2] + act_t[3];
    assign v_tot  = act_t[4] + act_t[5] + act_t[6] + act_t[7];
    assign h_last = (h == h_tot - CNT_W'(1));
    assign v_last = (v == v_tot - CNT_W'(1));
    assign wrap   = CE && h_last && v_last;

    assign h_nx = h_last ? '0 : h + CNT_W'(1);
    assign v_nx = h_last ? (v_last ? '0 : v + CNT_W'(1)) : v;

`ifdef VGA_TIMING_RUNTIME_CFG_EN
    timing_t stg_t;
    logic    pending;

    // Commit and staging write share an edge: the commit copies the pre-write
    // staging value, and the write lands in staging for the next frame.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            act_t   <= DEF_TIMING;
            stg_t   <= DEF_TIMING;
            pending <= 1'b0;
        end else begin
            if (wrap) begin
                act_t <= stg_t;
            end
            if (CFG_WR) begin
                stg_t[CFG_ADDR] <= CFG_DATA;
                pending         <= 1'b1;
            end else if (wrap) begin
                pending <= 1'b0;
            end
        end
    end

    assign CFG_PENDING = pending;

    // The (0,0) state after a commit is already judged against the new timing.
    always_comb begin
        nxt_t = act_t;
        if (wrap) begin
            nxt_t = stg_t;
        end
    end
`else
    assign act_t = DEF_TIMING;
    assign nxt_t = DEF_TIMING;
`endif

    // Outputs are decoded from the next position so they register on the same
    // edge as h/v and stay a pure function of the current (h,v).
    always_comb begin
        hs_beg = nxt_t[0] + nxt_t[1];
        hs_end = hs_beg + nxt_t[2];
        vs_beg = nxt_t[4] + nxt_t[5];
        vs_end = vs_beg + nxt_t[6];
        hs_in  = (h_nx >= hs_beg) && (h_nx < hs_end);
        vs_in  = (v_nx >= vs_beg) && (v_nx < vs_end);
        de_in  = (h_nx < nxt_t[0]) && (v_nx < nxt_t[4]);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            h           <= H_RST;
            v           <= V_RST;
            HSYNC       <= !HS_ON;
            VSYNC       <= !VS_ON;
            DE          <= 1'b0;
            LINE_START  <= 1'b0;
            FRAME_START <= 1'b0;
        end else if (CE) begin
            h           <= h_nx;
            v           <= v_nx;
            HSYNC       <= hs_in ? HS_ON : !HS_ON;
            VSYNC       <= vs_in ? VS_ON : !VS_ON;
            DE          <= de_in;
            LINE_START  <= (h_nx == '0);
            FRAME_START <= (h_nx == '0) && (v_nx == '0);
        end
    end

    assign X = h;
    assign Y = v;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized model-checked bench for vga_timing_gen
module tb_vga_timing_gen;

    localparam int CW = 8;
    localparam int HD = 8, HF = 2, HS = 3, HB = 2;
    localparam int VD = 5, VF = 1, VS = 2, VB = 1;
    localparam int HP = 1, VP = 0;
    localparam int HT0 = HD + HF + HS + HB;   // 15
    localparam int VT0 = VD + VF + VS + VB;   // 9
    localparam int DEF [8] = '{HD, HF, HS, HB, VD, VF, VS, VB};

    logic          CLK = 1'b0;
    logic          RESET_N;
    logic          CE;
    logic          HSYNC, VSYNC, DE, LINE_START, FRAME_START;
    logic [CW-1:0] X, Y;
`ifdef VGA_TIMING_RUNTIME_CFG_EN
    logic          CFG_WR = 1'b0;
    logic [2:0]    CFG_ADDR = 3'd0;
    logic [CW-1:0] CFG_DATA = '0;
    logic          CFG_PENDING;
`endif

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    vga_timing_gen #(
        .CNT_W(CW), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_POL(HP), .V_POL(VP)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .CE(CE),
        .HSYNC(HSYNC), .VSYNC(VSYNC), .DE(DE), .X(X), .Y(Y),
        .LINE_START(LINE_START), .FRAME_START(FRAME_START)
`ifdef VGA_TIMING_RUNTIME_CFG_EN
        ,
        .CFG_WR(CFG_WR), .CFG_ADDR(CFG_ADDR), .CFG_DATA(CFG_DATA),
        .CFG_PENDING(CFG_PENDING)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0d exp=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the frame is a linear index k = v*H_TOT + h; reset parks at the last index.
    int   k;
    int   mt [8];
    int   ms [8];
    logic mpend;
    int   m_ht, m_vt;

    always_comb begin
        m_ht = mt[0] + mt[1] + mt[2] + mt[3];
        m_vt = mt[4] + mt[5] + mt[6] + mt[7];
    end

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            k     <= HT0 * VT0 - 1;
            mt    <= DEF;
            ms    <= DEF;
            mpend <= 1'b0;
        end else begin
            if (CE) begin
                if (k == m_ht * m_vt - 1) begin
                    k  <= 0;
                    mt <= ms;
                end else begin
                    k <= k + 1;
                end
            end
`ifdef VGA_TIMING_RUNTIME_CFG_EN
            if (CFG_WR) begin
                ms[CFG_ADDR] <= int'(CFG_DATA);
                mpend        <= 1'b1;
            end else if (CE && k == m_ht * m_vt - 1) begin
                mpend <= 1'b0;
            end
`endif
        end
    end

    task automatic check_model();
        int h, v, hsb, vsb;
        h   = k % m_ht;
        v   = k / m_ht;
        hsb = mt[0] + mt[1];
        vsb = mt[4] + mt[5];
        chk("x", int'(X), h);
        chk("y", int'(Y), v);
        chk("de", int'(DE), int'(h < mt[0] && v < mt[4]));
        chk("hsync", int'(HSYNC), (h >= hsb && h < hsb + mt[2]) ? HP : 1 - HP);
        chk("vsync", int'(VSYNC), (v >= vsb && v < vsb + mt[6]) ? VP : 1 - VP);
        chk("line_start", int'(LINE_START), int'(h == 0));
        chk("frame_start", int'(FRAME_START), int'(h == 0 && v == 0));
`ifdef VGA_TIMING_RUNTIME_CFG_EN
        chk("cfg_pending", int'(CFG_PENDING), int'(mpend));
`endif
    endtask

    always @(negedge CLK) begin
        if (chk_en) check_model();
    end

    task automatic check_reset_literals(input string tag);
        chk({tag, "_x"}, int'(X), HT0 - 1);
        chk({tag, "_y"}, int'(Y), VT0 - 1);
        chk({tag, "_de"}, int'(DE), 0);
        chk({tag, "_hsync"}, int'(HSYNC), 1 - HP);
        chk({tag, "_vsync"}, int'(VSYNC), 1 - VP);
        chk({tag, "_ls"}, int'(LINE_START), 0);
        chk({tag, "_fs"}, int'(FRAME_START), 0);
    endtask

    initial begin
        int n_hs, n_vs, n_de, n_ls, n_fs;
        RESET_N = 1'b1;
        CE      = 1'b0;
        #2 RESET_N = 1'b0;
        repeat (3) @(negedge CLK);
        chk_en = 1'b1;
        check_reset_literals("rst");

        // Release with CE=0: nothing moves.
        RESET_N = 1'b1;
        @(negedge CLK);
        chk("hold_x", int'(X), HT0 - 1);

        // First CE lands on (0,0).
        CE = 1'b1;
        @(negedge CLK);
        chk("first_x", int'(X), 0);
        chk("first_y", int'(Y), 0);
        chk("first_de", int'(DE), 1);
        chk("first_fs", int'(FRAME_START), 1);
        chk("first_ls", int'(LINE_START), 1);

        // One full frame at CE=1: per-frame counts from the timing parameters.
        n_hs = 0; n_vs = 0; n_de = 0; n_ls = 0; n_fs = 0;
        for (int i = 0; i < HT0 * VT0; i++) begin
            if (i > 0) @(negedge CLK);
            n_hs += int'(HSYNC == 1'b1);
            n_vs += int'(VSYNC == 1'b0);
            n_de += int'(DE);
            n_ls += int'(LINE_START);
            n_fs += int'(FRAME_START);
        end
        chk("cnt_hsync_hi", n_hs, 27);
        chk("cnt_vsync_lo", n_vs, 30);
        chk("cnt_de", n_de, 40);
        chk("cnt_line_start", n_ls, 9);
        chk("cnt_frame_start", n_fs, 1);

        // CE every second clock.
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            CE = (i % 2 == 0);
        end

`ifdef VGA_TIMING_RUNTIME_CFG_EN
        // Widen the active line mid-frame; it must only take effect after the wrap.
        CE = 1'b1;
        @(negedge CLK);
        CFG_WR = 1'b1; CFG_ADDR = 3'd0; CFG_DATA = CW'(12);
        @(negedge CLK);
        CFG_WR = 1'b0;
        chk("cfg_pending_set", int'(CFG_PENDING), 1);
        repeat (300) @(negedge CLK);
`endif

        // Random CE, occasional asynchronous mid-frame reset.
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            RESET_N = 1'b1;
            CE = ($urandom_range(0, 3) != 0);
`ifdef VGA_TIMING_RUNTIME_CFG_EN
            CFG_WR   = ($urandom_range(0, 49) == 0);
            CFG_ADDR = 3'($urandom_range(0, 7));
            CFG_DATA = CW'($urandom_range(1, 6));
`endif
            if ($urandom_range(0, 299) == 0) begin
                #2 RESET_N = 1'b0;
                #1 check_reset_literals("async_rst");
            end
        end

        @(negedge CLK);
        RESET_N = 1'b1;
        CE = 1'b0;
        @(negedge CLK);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
